// File: rtl/game_flow_ctrl_pkg.sv
// ==== skyhop_pkg : shared state, key-code and output-bit definitions for SkyHop ====
// ==== Rev 1.0 ====
`default_nettype none

package skyhop_pkg;

  typedef enum logic [3:0] {
    S_START   = 4'd0,
    S_PREPARE = 4'd1,
    S_IDLE    = 4'd2,
    S_JUMP_L  = 4'd3,
    S_JUMP_R  = 4'd4,
    S_FLY     = 4'd5,
    S_FALL    = 4'd6,
    S_PAUSE   = 4'd7,
    S_END     = 4'd8
  } state_e;

  localparam logic [1:0] K_NONE     = 2'b00;
  localparam logic [1:0] K_LEFT     = 2'b01;
  localparam logic [1:0] K_RIGHT    = 2'b10;
  localparam logic [1:0] K_SPACEBAR = 2'b11;

  localparam int O_START_SCR = 0;
  localparam int O_BLOCKS    = 1;
  localparam int O_TIME_BAR  = 2;
  localparam int O_CHARACTER = 3;
  localparam int O_POINTS    = 4;
  localparam int O_END_SCR   = 5;
  localparam int O_PAUSE_SCR = 6;
  localparam int O_BG_SEL    = 7;
  localparam int O_JUMP_L    = 8;
  localparam int O_JUMP_R    = 9;
  localparam int O_TMR_START = 10;
  localparam int O_TMR_HOLD  = 11;
  localparam int N_OUTS      = 12;

  typedef logic [N_OUTS-1:0] out_vec_t;

  // Moore decode: the full draw/strobe vector belonging to one state.
  function automatic out_vec_t decode_outputs(input state_e s);
    out_vec_t v;
    out_vec_t g;
    v = '0;
    g = '0;
    g[O_BLOCKS]    = 1'b1;
    g[O_TIME_BAR]  = 1'b1;
    g[O_CHARACTER] = 1'b1;
    g[O_POINTS]    = 1'b1;
    g[O_BG_SEL]    = 1'b1;
    case (s)
      S_START, S_PREPARE: v[O_START_SCR] = 1'b1;
      S_IDLE:  v = g;
      S_JUMP_L: begin
        v = g;
        v[O_JUMP_L]    = 1'b1;
        v[O_TMR_START] = 1'b1;
      end
      S_JUMP_R: begin
        v = g;
        v[O_JUMP_R]    = 1'b1;
        v[O_TMR_START] = 1'b1;
      end
      S_FLY: begin
        v = g;
        v[O_TMR_START] = 1'b1;
      end
      S_FALL: begin
        v = g;
        v[O_TMR_HOLD] = 1'b1;
      end
      S_PAUSE: begin
        v = g;
        v[O_PAUSE_SCR] = 1'b1;
        v[O_TMR_HOLD]  = 1'b1;
      end
      S_END:   v[O_END_SCR] = 1'b1;
      default: v[O_START_SCR] = 1'b1;
    endcase
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/game_flow_ctrl_if.sv
// ==== game_flow_ctrl_if : keyboard/physics inputs and draw/timer outputs of the sequencer ====
// ==== Rev 1.0 ====
`default_nettype none

interface game_flow_ctrl_if #(
  parameter int LIVES     = 3,
  parameter int MAX_LEVEL = 7
);
  localparam int LIVES_W = $clog2(LIVES + 1);
  localparam int LEVEL_W = $clog2(MAX_LEVEL + 1);

  logic [1:0]         key;
  logic               jump_fail;
  logic               time_elapsed;
  logic               character_landed;

  logic               start_screen_en;
  logic               blocks_en;
  logic               time_bar_en;
  logic               character_en;
  logic               points_en;
  logic               end_screen_en;
  logic               pause_screen_en;
  logic               bg_color_select;
  logic               jump_left;
  logic               jump_right;
  logic               timer_start;
  logic               timer_hold;
  logic               game_over;
  logic [LIVES_W-1:0] lives;
  logic [LEVEL_W-1:0] level;

  modport master (
    output key, jump_fail, time_elapsed, character_landed,
    input  start_screen_en, blocks_en, time_bar_en, character_en, points_en,
           end_screen_en, pause_screen_en, bg_color_select, jump_left, jump_right,
           timer_start, timer_hold, game_over, lives, level
  );

  modport slave (
    input  key, jump_fail, time_elapsed, character_landed,
    output start_screen_en, blocks_en, time_bar_en, character_en, points_en,
           end_screen_en, pause_screen_en, bg_color_select, jump_left, jump_right,
           timer_start, timer_hold, game_over, lives, level
  );

endinterface

`default_nettype wire

// File: rtl/game_flow_ctrl_key_press_detect.sv
// ==== key_press_detect : registers the key code and flags a new press as one-hot strobes ====
// ==== Rev 1.0 ====
`default_nettype none

module key_press_detect
  import skyhop_pkg::*;
(
  input  wire logic       clk,
  input  wire logic       rst,
  input  wire logic [1:0] key,
  output logic            press_left,
  output logic            press_right,
  output logic            press_space
);

  logic [1:0] key_q;
  logic [1:0] key_d;
  logic       press;

  // A held code matches key_q and so fires only on its first cycle.
  always_comb begin
    key_d       = key;
    press       = (key != K_NONE) && (key != key_q);
    press_left  = press && (key == K_LEFT);
    press_right = press && (key == K_RIGHT);
    press_space = press && (key == K_SPACEBAR);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      key_q <= K_NONE;
    end else begin
      key_q <= key_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/game_flow_ctrl.sv
// ==== game_flow_ctrl : SkyHop game sequencer with lives, pause, timed fall and levels ====
// ==== Rev 1.0 ====
`default_nettype none

module game_flow_ctrl
  import skyhop_pkg::*;
#(
  parameter int LIVES           = 3,
  parameter int FALL_CYCLES     = 60,
  parameter int JUMPS_PER_LEVEL = 8,
  parameter int MAX_LEVEL       = 7,
  parameter int PAUSE_EN        = 1
) (
  input  wire logic        clk,
  input  wire logic        rst,
  game_flow_ctrl_if.slave  bus
);

  localparam int LIVES_W = $clog2(LIVES + 1);
  localparam int LEVEL_W = $clog2(MAX_LEVEL + 1);
  localparam int FALL_W  = $clog2(FALL_CYCLES + 1);
  localparam int LAND_W  = $clog2(JUMPS_PER_LEVEL + 1);

  localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);
  localparam logic [LEVEL_W-1:0] LEVEL_TOP  = LEVEL_W'(MAX_LEVEL);
  localparam logic [FALL_W-1:0]  FALL_INIT  = FALL_W'(FALL_CYCLES - 1);
  localparam logic [LAND_W-1:0]  LAND_LAST  = LAND_W'(JUMPS_PER_LEVEL - 1);

  logic press_left;
  logic press_right;
  logic press_space;

  state_e             state_q, state_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [LAND_W-1:0]  land_q,  land_d;
  logic [FALL_W-1:0]  fall_q,  fall_d;
  out_vec_t           outs_q,  outs_d;
  logic               game_over_q, game_over_d;

  key_press_detect u_key_press_detect (
    .clk         (clk),
    .rst         (rst),
    .key         (bus.key),
    .press_left  (press_left),
    .press_right (press_right),
    .press_space (press_space)
  );

  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    level_d = level_q;
    land_d  = land_q;
    fall_d  = fall_q;
    case (state_q)
      S_START: begin
        if (press_space) begin
          state_d = S_PREPARE;
          lives_d = LIVES_INIT;
          level_d = '0;
          land_d  = '0;
        end
      end
      S_PREPARE: state_d = S_IDLE;
      S_IDLE: begin
        if (bus.time_elapsed)                  state_d = S_END;
        else if (press_left)                   state_d = S_JUMP_L;
        else if (press_right)                  state_d = S_JUMP_R;
        else if (press_space && PAUSE_EN != 0) state_d = S_PAUSE;
      end
      S_JUMP_L, S_JUMP_R: state_d = S_FLY;
      S_FLY: begin
        if (bus.jump_fail) begin
          state_d = S_FALL;
          fall_d  = FALL_INIT;
        end else if (bus.character_landed) begin
          state_d = S_IDLE;
          if (land_q == LAND_LAST) begin
            land_d = '0;
            if (level_q != LEVEL_TOP) level_d = level_q + LEVEL_W'(1);
          end else begin
            land_d = land_q + LAND_W'(1);
          end
        end
      end
      S_FALL: begin
        if (fall_q == '0) begin
          if (lives_q <= LIVES_W'(1)) begin
            state_d = S_END;
            lives_d = '0;
          end else begin
            state_d = S_PREPARE;
            lives_d = lives_q - LIVES_W'(1);
          end
        end else begin
          fall_d = fall_q - FALL_W'(1);
        end
      end
      S_PAUSE: if (press_space) state_d = S_IDLE;
      S_END:   if (press_space) state_d = S_START;
      default: state_d = S_START;
    endcase

    // Outputs are decoded from the next state so they land in the same cycle as the state.
    outs_d      = decode_outputs(state_d);
    game_over_d = (state_d == S_END) && (state_q != S_END);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_START;
      lives_q     <= LIVES_INIT;
      level_q     <= '0;
      land_q      <= '0;
      fall_q      <= '0;
      outs_q      <= decode_outputs(S_START);
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lives_q     <= lives_d;
      level_q     <= level_d;
      land_q      <= land_d;
      fall_q      <= fall_d;
      outs_q      <= outs_d;
      game_over_q <= game_over_d;
    end
  end

  assign bus.start_screen_en = outs_q[O_START_SCR];
  assign bus.blocks_en       = outs_q[O_BLOCKS];
  assign bus.time_bar_en     = outs_q[O_TIME_BAR];
  assign bus.character_en    = outs_q[O_CHARACTER];
  assign bus.points_en       = outs_q[O_POINTS];
  assign bus.end_screen_en   = outs_q[O_END_SCR];
  assign bus.pause_screen_en = outs_q[O_PAUSE_SCR];
  assign bus.bg_color_select = outs_q[O_BG_SEL];
  assign bus.jump_left       = outs_q[O_JUMP_L];
  assign bus.jump_right      = outs_q[O_JUMP_R];
  assign bus.timer_start     = outs_q[O_TMR_START];
  assign bus.timer_hold      = outs_q[O_TMR_HOLD];
  assign bus.game_over       = game_over_q;
  assign bus.lives           = lives_q;
  assign bus.level           = level_q;

endmodule

`default_nettype wire

// File: doc/game_flow_ctrl.md
# game_flow_ctrl

Parametrised top-level game sequencer for SkyHop. It adds multiple lives, a pause mode, a timed fall sequence, level progression and key-press edge detection. It decodes registered game state into per-layer draw enables and character/timer control strobes for the rendering and physics blocks. It sits between the keyboard decoder and the draw/timer/character modules.

## Interface
- LIVES, 3: lives per game; must be ≥1.
- FALL_CYCLES, 60: cycles spent in FALL before the life is deducted; must be ≥1.
- JUMPS_PER_LEVEL, 8: successful landings per level increment; must be ≥1.
- MAX_LEVEL, 7: level counter saturates here.
- PAUSE_EN, 1: 1 enables pause on spacebar in IDLE.
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- key  in  2  keyboard code: 00 none, 01 left, 10 right, 11 spacebar.
- jump_fail  in  1  character missed the block (physics).
- time_elapsed  in  1  time bar empty.
- character_landed  in  1  character reached a block.
- start_screen_en, blocks_en, time_bar_en, character_en, points_en, end_screen_en, pause_screen_en  out  1 each  draw-layer enables.
- bg_color_select  out  1  gameplay background select.
- jump_left, jump_right  out  1  one-cycle jump launch strobes.
- timer_start  out  1  time-bar restart.
- timer_hold  out  1  freeze time bar.
- game_over  out  1  one-cycle pulse on entry to END.
- lives  out  $clog2(LIVES+1)  remaining lives.
- level  out  $clog2(MAX_LEVEL+1)  current level.

## Operation
- Press detection: `key_q` registers key. A press means key≠00 and key≠key_q. A held key acts once only.
- Counters: landings count (0..JUMPS_PER_LEVEL-1) and fall countdown.
- States and transitions (Moore outputs decoded from state):
  - START: start_screen_en. Space press → PREPARE. Load lives=LIVES, level=0, landings=0.
  - PREPARE: start_screen_en. Goes unconditionally → IDLE.
  - IDLE: blocks, time_bar, character and points enables plus bg_color_select. Priority order:
    - time_elapsed → END.
    - left press → JUMP_L.
    - right press → JUMP_R.
    - space press with PAUSE_EN=1 → PAUSE.
    - otherwise stay.
  - JUMP_L / JUMP_R: gameplay enables, jump_left / jump_right, timer_start. Goes → FLY.
  - FLY: gameplay enables, timer_start.
    - jump_fail → FALL, load fall countdown FALL_CYCLES-1. jump_fail wins over a simultaneous character_landed.
    - character_landed → IDLE, landings+1. When landings wraps from JUMPS_PER_LEVEL-1 to 0, level+1, saturating at MAX_LEVEL.
  - FALL: gameplay enables, timer_hold.
    - Countdown decrements each cycle.
    - At 0: lives-1. If lives was 1 → END (lives=0); else → PREPARE.
    - time_elapsed and keys are ignored.
  - PAUSE: gameplay enables, pause_screen_en, timer_hold. Space press → IDLE. time_elapsed is ignored.
  - END: end_screen_en. Space press → START.
- game_over is asserted on the transition into END (from IDLE or FALL), for one cycle only.
- lives never underflows. level never exceeds MAX_LEVEL.

## Timing
- Reset (rst=0 at clock edge):
  - state=START, key_q=00, lives=LIVES, level=0, landings=0, fall countdown=0.
  - Outputs: start_screen_en=1, all other enables, strobes and game_over=0.
  - Reset overrides all other inputs at any state, including mid-FALL and mid-PAUSE.
- A press on edge n moves the state on edge n. The corresponding outputs are valid in cycle n+1, i.e. one-cycle latency from input to output.
- Jump strobes are high for exactly one cycle. FLY follows immediately.
- FALL lasts exactly FALL_CYCLES cycles.
- The lives decrement and the state change happen on the same edge.
- A key held from START through PREPARE into IDLE does not re-trigger.
- A press needs a release (00) or a different code first.

## Structure
- Shared package `skyhop_pkg`:
  - state encoding enum (4 bits, 9 states);
  - key codes K_NONE/K_LEFT/K_RIGHT/K_SPACEBAR;
  - output-vector bit-position constants.
- Sub-module `key_press_detect`: key register plus press decode. It outputs one-hot press_left/press_right/press_space.
- Remainder: one state register, a combinational next-state/output decode, and the counter registers.

## Test plan
- Reset mid-FALL with lives=2 → next cycle state START, lives=3, level=0, start_screen_en=1.
- Space, then left held for 5 cycles in IDLE → jump_left high for 1 cycle only; FLY; character_landed → IDLE, landings=1.
- JUMPS_PER_LEVEL=2, MAX_LEVEL=1, 6 landings → level goes 0→1 after the 2nd landing and stays 1.
- jump_fail and character_landed in the same FLY cycle, FALL_CYCLES=4 → FALL held 4 cycles with timer_hold=1, then PREPARE, lives 3→2.
- LIVES=1, a single failed jump → END after FALL, game_over pulse for 1 cycle, lives=0, end_screen_en=1.
- PAUSE_EN=1, space in IDLE, time_elapsed held high → remains in PAUSE with timer_hold=1. Space → IDLE, then END on the next edge.
